// File: rtl/frame_buf_sched_pkg.sv
// frame_buf_sched_pkg: FSM encoding and Avalon burst constants shared by frame_buf_sched
package frame_buf_sched_pkg;
  typedef enum logic [2:0] {S_IDLE, S_SEL, S_REQ, S_DRAIN, S_DONE} fsm_t;
  localparam logic [1:0] STATE_IDLE = 2'd3;
  localparam int BCNT_W = 7;
endpackage

// File: rtl/frame_buf_addr_gen.sv
// frame_buf_addr_gen: frame address / remaining-word counters and next burst length
module frame_buf_addr_gen
  import frame_buf_sched_pkg::*;
#(
  parameter int BURST_LEN = 16,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              issue,
  input  logic [ADDR_W-1:0] base,
  input  logic [29:0]       words,
  output logic [ADDR_W-1:0] addr,
  output logic [BCNT_W-1:0] blen,
  output logic              last
);
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [29:0] remain_q, remain_d;
  // full burst unless only a tail of the frame is left; advance on each accepted burst
  always_comb begin
    blen = remain_q >= 30'(BURST_LEN) ? BCNT_W'(BURST_LEN) : remain_q[BCNT_W-1:0];
    last = remain_q <= 30'(BURST_LEN);
    addr_d = load ? base : issue ? addr_q + ADDR_W'({blen, 2'b00}) : addr_q;
    remain_d = load ? words : issue ? remain_q - 30'(blen) : remain_q;
  end
  // counter registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q <= '0;
      remain_q <= '0;
    end else begin
      addr_q <= addr_d;
      remain_q <= remain_d;
    end
  end
  assign addr = addr_q;
endmodule

// File: rtl/frame_buf_sched.sv
// frame_buf_sched: double-buffered frame reader over Avalon-MM bursts; FRAME_BUF_SCHED_STATS_EN adds frame/repeat counters
module frame_buf_sched
  import frame_buf_sched_pkg::*;
#(
  parameter int BURST_LEN = 16,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       start_status,
  input  logic [31:0]       buffer_base,
  input  logic [31:0]       img_size,
  input  logic [1:0]        buffer_status,
  output logic [1:0]        state,
  output logic              img_end,
  output logic              avm_read,
  output logic [ADDR_W-1:0] avm_address,
  output logic [BCNT_W-1:0] avm_burstcount,
  input  logic              avm_waitrequest,
  input  logic              avm_readdatavalid,
  input  logic [31:0]       avm_readdata,
  input  logic [9:0]        fifo_space,
  output logic [31:0]       pix_data,
  output logic              pix_valid
`ifdef FRAME_BUF_SCHED_STATS_EN
  ,
  output logic [15:0]       frame_cnt,
  output logic [15:0]       repeat_cnt
`endif
);
  fsm_t fsm_q, fsm_d;
  logic [1:0] state_q, state_d;
  logic last_q, last_d, drop_q, drop_d, img_end_q, img_end_d;
  logic avm_read_q, read_d, pix_valid_q, pix_valid_d;
  logic [ADDR_W-1:0] avm_address_q, addr_d, agen_addr;
  logic [BCNT_W-1:0] avm_burstcount_q, bcnt_d, blen;
  logic [9:0] outst_q, outst_d;
  logic [31:0] pix_data_q, pix_data_d, frame_base;
  logic [29:0] words;
  logic issue, other, sel, rpt, enter_sel, last_burst, unused_bits;

  assign words = img_size[31:2];
  assign frame_base = state_q[0] ? buffer_base + {words, 2'b00} : buffer_base;
  assign unused_bits = ^{start_status[31:1], img_size[1:0]};

  frame_buf_addr_gen #(.BURST_LEN(BURST_LEN), .ADDR_W(ADDR_W)) u_addr_gen (
    .clk(clk),
    .rst_n(rst_n),
    .load(fsm_q == S_SEL),
    .issue(issue),
    .base(ADDR_W'(frame_base)),
    .words(words),
    .addr(agen_addr),
    .blen(blen),
    .last(last_burst)
  );

  // frame sequencing, buffer choice, flow-controlled burst requests and output staging
  always_comb begin
    issue = avm_read_q & ~avm_waitrequest;
    other = ~last_q;
    sel = buffer_status[other] ? other : last_q;
    rpt = ~buffer_status[other] & ~buffer_status[last_q];
    fsm_d = fsm_q;
    read_d = avm_read_q;
    addr_d = avm_address_q;
    bcnt_d = avm_burstcount_q;
    drop_d = drop_q;
    case (fsm_q)
      S_IDLE: if (start_status[0] && words != '0) begin
        fsm_d = S_SEL;
        drop_d = 1'b0;
      end
      S_SEL: fsm_d = words != '0 ? S_REQ : S_IDLE;
      S_REQ: if (issue) begin
        read_d = 1'b0;
        fsm_d = last_burst ? S_DRAIN : S_REQ;
      end else if (!avm_read_q && {1'b0, fifo_space} >= {1'b0, outst_q} + 11'(blen)) begin
        read_d = 1'b1;
        addr_d = agen_addr;
        bcnt_d = blen;
      end
      S_DRAIN: fsm_d = outst_q == '0 ? S_DONE : S_DRAIN;
      S_DONE: fsm_d = start_status[0] ? S_SEL : S_IDLE;
      default: fsm_d = S_IDLE;
    endcase
    enter_sel = fsm_d == S_SEL && fsm_q != S_SEL;
    state_d = fsm_d == S_IDLE ? STATE_IDLE : enter_sel ? {1'b0, sel} : state_q;
    last_d = enter_sel ? sel : last_q;
    img_end_d = fsm_d == S_DONE;
    outst_d = outst_q + (issue ? 10'(avm_burstcount_q) : 10'd0) - 10'(avm_readdatavalid & ~drop_q);
    pix_valid_d = avm_readdatavalid & ~drop_q;
    pix_data_d = pix_valid_d ? avm_readdata : pix_data_q;
  end

  // FSM and registered outputs; data returning after a reset is dropped until the next frame starts
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm_q <= S_IDLE;
      state_q <= STATE_IDLE;
      last_q <= 1'b1;
      drop_q <= 1'b1;
      img_end_q <= 1'b0;
      avm_read_q <= 1'b0;
      avm_address_q <= '0;
      avm_burstcount_q <= '0;
      outst_q <= '0;
      pix_valid_q <= 1'b0;
      pix_data_q <= '0;
    end else begin
      fsm_q <= fsm_d;
      state_q <= state_d;
      last_q <= last_d;
      drop_q <= drop_d;
      img_end_q <= img_end_d;
      avm_read_q <= read_d;
      avm_address_q <= addr_d;
      avm_burstcount_q <= bcnt_d;
      outst_q <= outst_d;
      pix_valid_q <= pix_valid_d;
      pix_data_q <= pix_data_d;
    end
  end

  assign state = state_q;
  assign img_end = img_end_q;
  assign avm_read = avm_read_q;
  assign avm_address = avm_address_q;
  assign avm_burstcount = avm_burstcount_q;
  assign pix_valid = pix_valid_q;
  assign pix_data = pix_data_q;

`ifdef FRAME_BUF_SCHED_STATS_EN
  logic [15:0] frame_cnt_q, frame_cnt_d, repeat_cnt_q, repeat_cnt_d;
  // completed-frame and repeat-selection counts, wrapping at 16 bits
  always_comb begin
    frame_cnt_d = frame_cnt_q + 16'(img_end_d);
    repeat_cnt_d = repeat_cnt_q + 16'(enter_sel & rpt);
  end
  // statistics registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_cnt_q <= '0;
      repeat_cnt_q <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      repeat_cnt_q <= repeat_cnt_d;
    end
  end
  assign frame_cnt = frame_cnt_q;
  assign repeat_cnt = repeat_cnt_q;
`endif
endmodule

// File: tb/tb_frame_buf_sched.sv
// tb_frame_buf_sched: directed checks of frame_buf_sched with a streaming Avalon slave model
module tb_frame_buf_sched;
  logic clk = 0;
  logic rst_n;
  logic [31:0] start_status, buffer_base, img_size;
  logic [1:0] buffer_status;
  logic [9:0] fifo_space;
  logic avm_waitrequest;
  logic avm_readdatavalid = 0;
  logic [31:0] avm_readdata = 0;
  logic [1:0] state;
  logic img_end, avm_read, pix_valid;
  logic [31:0] avm_address, pix_data;
  logic [6:0] avm_burstcount;
`ifdef FRAME_BUF_SCHED_STATS_EN
  logic [15:0] frame_cnt, repeat_cnt;
`endif

  int errs = 0, checks = 0;
  int pix_cnt = 0, end_cnt = 0, ovf = 0;
  logic rd_seen = 0;
  logic [31:0] first_pix = 0, last_pix = 0;
  logic [31:0] pend[$];
  logic [31:0] b_addr[$];
  int b_len[$];
  int b_st[$];

  frame_buf_sched dut (
    .clk(clk),
    .rst_n(rst_n),
    .start_status(start_status),
    .buffer_base(buffer_base),
    .img_size(img_size),
    .buffer_status(buffer_status),
    .state(state),
    .img_end(img_end),
    .avm_read(avm_read),
    .avm_address(avm_address),
    .avm_burstcount(avm_burstcount),
    .avm_waitrequest(avm_waitrequest),
    .avm_readdatavalid(avm_readdatavalid),
    .avm_readdata(avm_readdata),
    .fifo_space(fifo_space),
    .pix_data(pix_data),
    .pix_valid(pix_valid)
`ifdef FRAME_BUF_SCHED_STATS_EN
    ,
    .frame_cnt(frame_cnt),
    .repeat_cnt(repeat_cnt)
`endif
  );

  always #10 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // slave model: logs accepted bursts, returns one word per cycle (data = word address)
  always @(negedge clk) begin
    if (avm_read && !avm_waitrequest) begin
      if (pend.size() + int'(avm_readdatavalid) + int'(avm_burstcount) > int'(fifo_space)) ovf++;
      b_addr.push_back(avm_address);
      b_len.push_back(int'(avm_burstcount));
      b_st.push_back(int'(state));
    end
    if (avm_read) rd_seen = 1;
    if (pix_valid) begin
      if (pix_cnt == 0) first_pix = pix_data;
      last_pix = pix_data;
      pix_cnt++;
    end
    if (img_end) end_cnt++;
    if (pend.size() > 0) begin
      avm_readdata = pend.pop_front();
      avm_readdatavalid = 1;
    end else avm_readdatavalid = 0;
    if (avm_read && !avm_waitrequest)
      for (int i = 0; i < int'(avm_burstcount); i++) pend.push_back(avm_address + 32'(i * 4));
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_end(input string tag);
    int n = 0;
    while (img_end !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_img_end"}, 32'(img_end), 32'd1);
  endtask

  task automatic clr();
    pend.delete();
    b_addr.delete();
    b_len.delete();
    b_st.delete();
    pix_cnt = 0;
    end_cnt = 0;
    ovf = 0;
    rd_seen = 0;
  endtask

  initial begin
    rst_n = 0;
    start_status = 0;
    buffer_base = 32'h1000_0000;
    img_size = 256;
    buffer_status = 2'b01;
    fifo_space = 10'd512;
    avm_waitrequest = 0;
    cyc(3);
    chk("rst_state", 32'(state), 32'd3);
    chk("rst_read", 32'(avm_read), 32'd0);
    chk("rst_addr", avm_address, 32'd0);
    chk("rst_bcnt", 32'(avm_burstcount), 32'd0);
    chk("rst_img_end", 32'(img_end), 32'd0);
    chk("rst_pix_valid", 32'(pix_valid), 32'd0);
    // 256-byte frame from buffer0
    clr();
    rst_n = 1;
    start_status = 1;
    wait_end("f256");
    chk("f256_state", 32'(state), 32'd0);
    start_status = 0;
    cyc(2);
    chk("f256_bursts", b_addr.size(), 32'd4);
    chk("f256_a0", b_addr[0], 32'h1000_0000);
    chk("f256_a1", b_addr[1], 32'h1000_0040);
    chk("f256_a2", b_addr[2], 32'h1000_0080);
    chk("f256_a3", b_addr[3], 32'h1000_00C0);
    chk("f256_len3", b_len[3], 32'd16);
    chk("f256_st3", b_st[3], 32'd0);
    chk("f256_pix", pix_cnt, 32'd64);
    chk("f256_first_pix", first_pix, 32'h1000_0000);
    chk("f256_ends", end_cnt, 32'd1);
    chk("f256_idle", 32'(state), 32'd3);
    // 200-byte frame from buffer1 at base+200
    clr();
    img_size = 200;
    buffer_status = 2'b10;
    start_status = 1;
    wait_end("f200");
    chk("f200_state", 32'(state), 32'd1);
    start_status = 0;
    cyc(2);
    chk("f200_bursts", b_addr.size(), 32'd4);
    chk("f200_a0", b_addr[0], 32'h1000_00C8);
    chk("f200_a3", b_addr[3], 32'h1000_0188);
    chk("f200_len0", b_len[0], 32'd16);
    chk("f200_len3", b_len[3], 32'd2);
    chk("f200_pix", pix_cnt, 32'd50);
    chk("f200_last_pix", last_pix, 32'h1000_018C);
    // alternating buffers with both fresh
    clr();
    img_size = 64;
    buffer_status = 2'b11;
    start_status = 1;
    for (int k = 0; k < 4; k++) begin
      wait_end("alt");
      chk("alt_state", 32'(state), 32'(k % 2));
      if (k == 3) start_status = 0;
      cyc(1);
    end
    cyc(2);
    chk("alt_frames", end_cnt, 32'd4);
    // no fresh buffer after first frame -> buffer0 repeated
    clr();
    buffer_status = 2'b01;
    start_status = 1;
    wait_end("rep1");
    chk("rep1_state", 32'(state), 32'd0);
    buffer_status = 2'b00;
    cyc(1);
    wait_end("rep2");
    chk("rep2_state", 32'(state), 32'd0);
    start_status = 0;
    cyc(2);
    chk("rep2_addr", b_addr[1], 32'h1000_0000);
`ifdef FRAME_BUF_SCHED_STATS_EN
    chk("rep_cnt", 32'(repeat_cnt), 32'd1);
    chk("frame_cnt", 32'(frame_cnt), 32'd8);
`endif
    // FIFO back-pressure and waitrequest stalls
    clr();
    buffer_status = 2'b01;
    fifo_space = 10'd10;
    start_status = 1;
    cyc(12);
    chk("fifo10_no_read", 32'(rd_seen), 32'd0);
    chk("fifo10_state", 32'(state), 32'd0);
    avm_waitrequest = 1;
    fifo_space = 10'd16;
    cyc(1);
    chk("fifo16_read", 32'(avm_read), 32'd1);
    chk("fifo16_addr", avm_address, 32'h1000_0000);
    chk("fifo16_bcnt", 32'(avm_burstcount), 32'd16);
    cyc(5);
    chk("wait_read", 32'(avm_read), 32'd1);
    chk("wait_addr", avm_address, 32'h1000_0000);
    chk("wait_bcnt", 32'(avm_burstcount), 32'd16);
    avm_waitrequest = 0;
    wait_end("fifo");
    start_status = 0;
    cyc(2);
    chk("fifo_pix", pix_cnt, 32'd16);
    chk("fifo_bursts", b_addr.size(), 32'd1);
    // issues overlapping returning data under a tight FIFO budget
    clr();
    fifo_space = 10'd32;
    img_size = 256;
    start_status = 1;
    wait_end("ovl");
    start_status = 0;
    cyc(2);
    chk("ovl_overrun", ovf, 32'd0);
    chk("ovl_pix", pix_cnt, 32'd64);
    chk("ovl_bursts", b_addr.size(), 32'd4);
    fifo_space = 10'd512;
    // start cleared mid-frame
    clr();
    start_status = 1;
    for (int n = 0; n < 50 && avm_read !== 1'b1; n++) cyc(1);
    chk("mid_read", 32'(avm_read), 32'd1);
    start_status = 0;
    wait_end("mid");
    chk("mid_state", 32'(state), 32'd0);
    cyc(2);
    chk("mid_idle", 32'(state), 32'd3);
    chk("mid_pix", pix_cnt, 32'd64);
    chk("mid_ends", end_cnt, 32'd1);
    // reset mid-burst: outputs cleared, stale data dropped
    clr();
    start_status = 1;
    for (int n = 0; n < 100 && b_addr.size() < 2; n++) cyc(1);
    chk("rb_bursts", 32'(b_addr.size() >= 2), 32'd1);
    rst_n = 0;
    start_status = 0;
    cyc(1);
    chk("rb_state", 32'(state), 32'd3);
    chk("rb_read", 32'(avm_read), 32'd0);
    chk("rb_addr", avm_address, 32'd0);
    chk("rb_bcnt", 32'(avm_burstcount), 32'd0);
    chk("rb_img_end", 32'(img_end), 32'd0);
    chk("rb_pix_valid", 32'(pix_valid), 32'd0);
    chk("rb_pix_data", pix_data, 32'd0);
    pix_cnt = 0;
    rst_n = 1;
    cyc(80);
    chk("rb_stale_pix", pix_cnt, 32'd0);
    chk("rb_drained", pend.size(), 32'd0);
    clr();
    buffer_base = 32'h2000_0000;
    img_size = 64;
    start_status = 1;
    wait_end("post");
    start_status = 0;
    cyc(2);
    chk("post_pix", pix_cnt, 32'd16);
    chk("post_first_pix", first_pix, 32'h2000_0000);
    chk("post_addr", b_addr[0], 32'h2000_0000);
`ifdef FRAME_BUF_SCHED_STATS_EN
    chk("post_frame_cnt", 32'(frame_cnt), 32'd1);
    chk("post_rep_cnt", 32'(repeat_cnt), 32'd0);
`endif
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
